// File: rtl/jtframe_pkg.sv
// jtframe_pkg
//  Shared types and constants for the 93Cxx Microwire EEPROM model. Kept in a
//  package so that CPU-side test models can drive the part with the same
//  state names and opcode values.
//  Contents: serial FSM state type, 2-bit opcode and extended-opcode values,
//  decoded command type, and small helper functions.
package jtframe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPC,
        ST_ADDR,
        ST_DIN,
        ST_DOUT,
        ST_WAIT,
        ST_PROG
    } state_t;

    // Two opcode bits following the start bit
    localparam logic [1:0] OP_EXT   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ERASE = 2'b11;

    // Extended opcodes live in the two address MSBs
    localparam logic [1:0] EXT_EWDS = 2'b00;
    localparam logic [1:0] EXT_WRAL = 2'b01;
    localparam logic [1:0] EXT_ERAL = 2'b10;
    localparam logic [1:0] EXT_EWEN = 2'b11;

    typedef enum logic [2:0] {
        CMD_READ,
        CMD_WRITE,
        CMD_ERASE,
        CMD_EWEN,
        CMD_EWDS,
        CMD_WRAL,
        CMD_ERAL
    } cmd_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic cmd_t decode_cmd(input logic [1:0] op, input logic [1:0] ext);
        cmd_t cmd;
        cmd = CMD_READ;
        case (op)
            OP_READ:  cmd = CMD_READ;
            OP_WRITE: cmd = CMD_WRITE;
            OP_ERASE: cmd = CMD_ERASE;
            default: begin
                case (ext)
                    EXT_EWEN: cmd = CMD_EWEN;
                    EXT_WRAL: cmd = CMD_WRAL;
                    EXT_ERAL: cmd = CMD_ERAL;
                    default:  cmd = CMD_EWDS;
                endcase
            end
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// jtframe_dual_ram
//  Simple dual-port RAM with registered reads on both ports.
//  Port A: serial engine (read/write). Port B: NVRAM dump (read/write).
//  When both ports write the same word in one clk, port B lands last.
//  Ports: clk; we_a/addr_a/din_a/q_a; we_b/addr_b/din_b/q_b.
module jtframe_dual_ram #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] din_a,
    output logic [DW-1:0] q_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] din_b,
    output logic [DW-1:0] q_b
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end

endmodule

// File: rtl/jtframe_93cxx.sv
// jtframe_93cxx
//  93Cxx Microwire serial EEPROM model. The CPU bit-bangs scs/sclk/sdi; all
//  serial pins are oversampled on clk. Supports READ (sequential), WRITE,
//  ERASE, EWEN, EWDS, WRAL, ERAL with a timed busy/ready phase and a dump
//  port for NVRAM save/restore.
//  Ports: clk, rst (sync, active high); scs, sclk, sdi serial inputs;
//  sdo serial data / ready(1) busy(0); busy programming flag;
//  dump_addr/dump_we/dump_din/dump_dout dump port (1 clk read latency).
module jtframe_93cxx
    import jtframe_pkg::*;
#(
    parameter int DW          = 16,
    parameter int AW          = 6,
    parameter int PROG_CYCLES = 4096,
    parameter bit WEN_RST     = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scs,
    input  logic          sclk,
    input  logic          sdi,
    output logic          sdo,
    output logic          busy,
    input  logic [AW-1:0] dump_addr,
    input  logic          dump_we,
    input  logic [DW-1:0] dump_din,
    output logic [DW-1:0] dump_dout
);

    localparam int CW  = $clog2(max_int(AW, DW) + 1);
    localparam int BCW = $clog2(PROG_CYCLES + (1 << AW) + 1);
    localparam logic [BCW-1:0] PROG_LAST = BCW'(PROG_CYCLES - 1);
    localparam logic [CW-1:0]  ADDR_LAST = CW'(AW - 1);
    localparam logic [CW-1:0]  DATA_LAST = CW'(DW - 1);

    state_t          state_reg;
    cmd_t            cmd_reg;
    logic [1:0]      op_reg;
    logic [CW-1:0]   bit_cnt_reg;
    logic [AW-1:0]   addr_reg;
    logic [DW-1:0]   data_reg;
    logic            wen_reg;
    logic            busy_reg;
    logic [BCW-1:0]  busy_cnt_reg;
    logic [AW-1:0]   walk_addr_reg;
    logic            walking_reg;
    logic            commit_pend_reg;
    logic            sdo_reg;
    logic            sclk_l;
    logic            scs_l;

    logic            rise;
    logic            scs_fall;
    logic [AW-1:0]   addr_shift;
    logic [DW-1:0]   data_shift;
    cmd_t            next_cmd;
    logic            prog_cmd;
    logic            single_cmd;
    logic            enter_prog;
    logic            single_wr;
    logic            walk_wr;
    logic            prog_done;
    logic            ram_we_a;
    logic [AW-1:0]   ram_addr_a;
    logic [DW-1:0]   ram_din_a;
    logic [DW-1:0]   ram_q_a;

    assign rise       = sclk & ~sclk_l;
    assign scs_fall   = ~scs & scs_l;
    assign addr_shift = {addr_reg[AW-2:0], sdi};
    assign data_shift = {data_reg[DW-2:0], sdi};
    // Extended commands are decoded from the completed address MSBs
    assign next_cmd   = decode_cmd(op_reg, addr_shift[AW-1:AW-2]);

    assign prog_cmd   = (cmd_reg == CMD_WRITE) || (cmd_reg == CMD_ERASE) ||
                        (cmd_reg == CMD_WRAL)  || (cmd_reg == CMD_ERAL);
    assign single_cmd = (cmd_reg == CMD_WRITE) || (cmd_reg == CMD_ERASE);
    assign enter_prog = (state_reg == ST_WAIT) && scs_fall && prog_cmd && wen_reg;

    // A single-word commit happens on PROG entry; if the dump port grabs the
    // RAM that clk, commit_pend_reg retries it on the next one.
    assign single_wr  = (enter_prog && single_cmd) ||
                        ((state_reg == ST_PROG) && commit_pend_reg);
    assign walk_wr    = (state_reg == ST_PROG) && walking_reg;
    assign ram_we_a   = !rst && !dump_we && (single_wr || walk_wr);
    assign ram_addr_a = walk_wr ? walk_addr_reg : addr_reg;
    assign ram_din_a  = ((cmd_reg == CMD_ERASE) || (cmd_reg == CMD_ERAL)) ?
                        {DW{1'b1}} : data_reg;

    // Busy only ends once the minimum time has elapsed and all writes landed
    assign prog_done  = (busy_cnt_reg >= PROG_LAST) && !walking_reg && !commit_pend_reg;

    assign sdo  = sdo_reg;
    assign busy = busy_reg;

    jtframe_dual_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk    (clk),
        .we_a   (ram_we_a),
        .addr_a (ram_addr_a),
        .din_a  (ram_din_a),
        .q_a    (ram_q_a),
        .we_b   (dump_we),
        .addr_b (dump_addr),
        .din_b  (dump_din),
        .q_b    (dump_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cmd_reg         <= CMD_READ;
            op_reg          <= 2'b00;
            bit_cnt_reg     <= '0;
            addr_reg        <= '0;
            data_reg        <= '0;
            wen_reg         <= WEN_RST;
            busy_reg        <= 1'b0;
            busy_cnt_reg    <= '0;
            walk_addr_reg   <= '0;
            walking_reg     <= 1'b0;
            commit_pend_reg <= 1'b0;
            sdo_reg         <= 1'b1;
            // sclk_l starts high so a held-high sclk is not taken as a rise
            sclk_l          <= 1'b1;
            scs_l           <= 1'b0;
        end else begin
            sclk_l <= sclk;
            scs_l  <= scs;
            if (state_reg == ST_PROG) begin
                // Serial input is ignored while programming
                if (commit_pend_reg && !dump_we) commit_pend_reg <= 1'b0;
                if (walking_reg && !dump_we) begin
                    walk_addr_reg <= walk_addr_reg + 1'b1;
                    if (walk_addr_reg == {AW{1'b1}}) walking_reg <= 1'b0;
                end
                if (prog_done) begin
                    busy_reg     <= 1'b0;
                    busy_cnt_reg <= '0;
                    state_reg    <= ST_IDLE;
                end else begin
                    busy_cnt_reg <= busy_cnt_reg + 1'b1;
                end
                sdo_reg <= scs ? prog_done : 1'b1;
            end else if (!scs) begin
                sdo_reg <= 1'b1;
                if (enter_prog) begin
                    state_reg       <= ST_PROG;
                    busy_reg        <= 1'b1;
                    busy_cnt_reg    <= '0;
                    walk_addr_reg   <= '0;
                    walking_reg     <= (cmd_reg == CMD_WRAL) || (cmd_reg == CMD_ERAL);
                    commit_pend_reg <= single_cmd && dump_we;
                end else begin
                    state_reg <= ST_IDLE;
                end
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        sdo_reg <= 1'b1;
                        // Leading zeros before the start bit are skipped
                        if (rise && sdi) begin
                            state_reg   <= ST_OPC;
                            bit_cnt_reg <= '0;
                        end
                    end
                    ST_OPC: begin
                        if (rise) begin
                            op_reg <= {op_reg[0], sdi};
                            if (bit_cnt_reg == CW'(1)) begin
                                state_reg   <= ST_ADDR;
                                bit_cnt_reg <= '0;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (rise) begin
                            addr_reg <= addr_shift;
                            if (bit_cnt_reg == ADDR_LAST) begin
                                cmd_reg     <= next_cmd;
                                bit_cnt_reg <= '0;
                                case (next_cmd)
                                    CMD_READ: begin
                                        state_reg <= ST_DOUT;
                                        sdo_reg   <= 1'b0;   // dummy bit
                                    end
                                    CMD_WRITE, CMD_WRAL: state_reg <= ST_DIN;
                                    CMD_EWEN: begin
                                        wen_reg   <= 1'b1;
                                        state_reg <= ST_WAIT;
                                    end
                                    CMD_EWDS: begin
                                        wen_reg   <= 1'b0;
                                        state_reg <= ST_WAIT;
                                    end
                                    default: state_reg <= ST_WAIT;
                                endcase
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                    ST_DIN: begin
                        if (rise) begin
                            data_reg <= data_shift;
                            if (bit_cnt_reg == DATA_LAST) begin
                                state_reg   <= ST_WAIT;
                                bit_cnt_reg <= '0;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                    ST_DOUT: begin
                        if (rise) begin
                            // First bit of each word comes straight from the RAM,
                            // the rest from the shift register
                            if (bit_cnt_reg == '0) begin
                                sdo_reg  <= ram_q_a[DW-1];
                                data_reg <= {ram_q_a[DW-2:0], 1'b0};
                            end else begin
                                sdo_reg  <= data_reg[DW-1];
                                data_reg <= {data_reg[DW-2:0], 1'b0};
                            end
                            if (bit_cnt_reg == DATA_LAST) begin
                                // Sequential read: next word is fetched well
                                // before the following rise
                                addr_reg    <= addr_reg + 1'b1;
                                bit_cnt_reg <= '0;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_93cxx.sv
// tb_jtframe_93cxx
//  Directed bench for jtframe_93cxx: bit-bangs Microwire commands and checks
//  sdo, busy and the array contents (via serial reads and the dump port)
//  against hand-computed values held in a small word model.
module tb_jtframe_93cxx;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int PC = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scs = 1'b0;
    logic          sclk = 1'b0;
    logic          sdi = 1'b0;
    logic          sdo;
    logic          busy;
    logic [AW-1:0] dump_addr = '0;
    logic          dump_we = 1'b0;
    logic [DW-1:0] dump_din = '0;
    logic [DW-1:0] dump_dout;

    int total = 0;
    int bad   = 0;
    int busy_cycles = 0;
    logic [DW-1:0] model [0:(1<<AW)-1];

    jtframe_93cxx #(
        .DW          (DW),
        .AW          (AW),
        .PROG_CYCLES (PC),
        .WEN_RST     (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scs       (scs),
        .sclk      (sclk),
        .sdi       (sdi),
        .sdo       (sdo),
        .busy      (busy),
        .dump_addr (dump_addr),
        .dump_we   (dump_we),
        .dump_din  (dump_din),
        .dump_dout (dump_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (busy === 1'b1) busy_cycles <= busy_cycles + 1;

    initial begin
        #900_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One serial bit: sclk low phase with sdi set, then high phase; sdo is
    // sampled at the end of the high phase.
    task automatic sbit(input logic b, output logic so);
        @(negedge clk);
        sclk = 1'b0;
        sdi  = b;
        repeat (3) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        so = sdo;
    endtask

    task automatic send(input logic [31:0] bits, input int n, output logic so);
        for (int i = n - 1; i >= 0; i--) sbit(bits[i], so);
    endtask

    task automatic select();
        @(negedge clk);
        sclk = 1'b0;
        sdi  = 1'b0;
        scs  = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic deselect();
        @(negedge clk);
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        scs = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 1000; i++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic read_check(input logic [AW-1:0] a, input int n, input string tag);
        logic so;
        logic [DW-1:0] w;
        logic [AW-1:0] ai;
        select();
        send({23'b0, 1'b1, 2'b10, a}, 9, so);
        check({tag, " dummy"}, so, 1'b0);
        ai = a;
        for (int k = 0; k < n; k++) begin
            for (int b = DW - 1; b >= 0; b--) begin
                sbit(1'b0, so);
                w[b] = so;
            end
            check(tag, w, model[ai]);
            ai = ai + 1'b1;
        end
        deselect();
    endtask

    task automatic dump_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        dump_addr = a;
        @(negedge clk);
        d = dump_dout;
    endtask

    task automatic dump_fill(input logic [DW-1:0] base);
        for (int i = 0; i < (1 << AW); i++) begin
            @(negedge clk);
            dump_we   = 1'b1;
            dump_addr = AW'(i);
            dump_din  = base + DW'(i);
            model[i]  = base + DW'(i);
        end
        @(negedge clk);
        dump_we = 1'b0;
    endtask

    initial begin
        logic so;
        logic [DW-1:0] d;
        int busy_n;
        int sdo_n;
        int b0;
        logic done;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst sdo", sdo, 1'b1);
        check("rst busy", busy, 1'b0);

        // Known array contents through the dump port
        dump_fill(16'h0100);
        dump_read(6'd5, d);
        check("dump rd5", d, 16'h0105);
        dump_read(6'd63, d);
        check("dump rd63", d, 16'h013F);

        // 1: WRITE while write-disabled changes nothing and never goes busy
        b0 = busy_cycles;
        select();
        send({7'b0, 1'b1, 2'b01, 6'd5, 16'h1234}, 25, so);
        deselect();
        repeat (10) @(negedge clk);
        check("t1 busy cycles", 32'(busy_cycles - b0), 32'd0);
        read_check(6'd5, 1, "t1 read5");

        // 2: EWEN, then WRITE with timed busy; scs raised one clk into PROG
        select();
        send({23'b0, 1'b1, 2'b00, 6'b110000}, 9, so);
        deselect();
        check("t2 ewen no busy", busy, 1'b0);
        select();
        send({7'b0, 1'b1, 2'b01, 6'd5, 16'hA5C3}, 25, so);
        @(negedge clk);
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        scs = 1'b0;
        @(negedge clk);
        check("t2 busy entry", busy, 1'b1);
        busy_n = (busy === 1'b1) ? 1 : 0;
        sdo_n  = 0;
        done   = 1'b0;
        scs    = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (sdo === 1'b0) sdo_n++;
            if (busy === 1'b0 && sdo === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        check("t2 ready", done, 1'b1);
        check("t2 busy len", busy_n, PC);
        check("t2 sdo low len", sdo_n, PC - 1);
        model[5] = 16'hA5C3;
        deselect();
        read_check(6'd5, 1, "t2 read5");

        // 3: sequential read wrapping from the top address
        read_check(6'd63, 2, "t3 seq");

        // ERASE of a single word
        select();
        send({23'b0, 1'b1, 2'b11, 6'd3}, 9, so);
        deselect();
        wait_idle("erase done");
        model[3] = 16'hFFFF;
        read_check(6'd3, 1, "erase read3");

        // 4: WRAL then ERAL
        select();
        send({23'b0, 1'b1, 2'b00, 6'b110000}, 9, so);
        deselect();
        select();
        send({7'b0, 1'b1, 2'b00, 6'b010000, 16'h00FF}, 25, so);
        deselect();
        wait_idle("wral done");
        for (int i = 0; i < (1 << AW); i++) model[i] = 16'h00FF;
        read_check(6'd0, 1, "t4 wral0");
        read_check(6'd17, 1, "t4 wral17");
        read_check(6'd63, 1, "t4 wral63");
        select();
        send({23'b0, 1'b1, 2'b00, 6'b100000}, 9, so);
        deselect();
        wait_idle("eral done");
        for (int i = 0; i < (1 << AW); i++) model[i] = 16'hFFFF;
        read_check(6'd17, 1, "t4 eral17");

        // 5: dump write in the same clk as the serial commit; serial lands last
        select();
        send({7'b0, 1'b1, 2'b01, 6'd9, 16'h5A5A}, 25, so);
        @(negedge clk);
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        scs       = 1'b0;
        dump_we   = 1'b1;
        dump_addr = 6'd9;
        dump_din  = 16'hDEAD;
        @(negedge clk);
        dump_we = 1'b0;
        wait_idle("t5 done");
        dump_read(6'd9, d);
        check("t5 word9", d, 16'h5A5A);

        // 6: reset during the WRAL walk after ten words have been written
        dump_fill(16'h0200);
        select();
        send({23'b0, 1'b1, 2'b00, 6'b110000}, 9, so);
        deselect();
        select();
        send({7'b0, 1'b1, 2'b00, 6'b010000, 16'h1111}, 25, so);
        @(negedge clk);
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        scs = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6 busy", busy, 1'b0);
        check("t6 sdo", sdo, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) model[i] = 16'h1111;
        for (int i = 0; i < (1 << AW); i++) begin
            dump_read(AW'(i), d);
            check($sformatf("t6 word%0d", i), d, model[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
